// File: rtl/doorlock_pkg.sv
// Shared constants, FSM state type and key map for the door-lock keypad path.
package doorlock_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 3;
    localparam int unsigned NUM_KEYS = NUM_ROWS * NUM_COLS;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    // Snapshot bit index (row*3+col) to key code.
    // Rows 0..2 carry digits 1..9 in order; row 3 is `*`, 0, `#`.
    function automatic logic [3:0] key_of_idx(input logic [3:0] idx);
        case (idx)
            4'd9:    key_of_idx = KEY_STAR;
            4'd10:   key_of_idx = 4'd0;
            4'd11:   key_of_idx = KEY_HASH;
            default: key_of_idx = idx + 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous level inputs.
module sync2 #(
    parameter int unsigned          WIDTH   = 1,
    parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    // Next values: shift the input through the two stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchroniser flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: column scan, frame debounce, one event per press.
module keypad_scanner
    import doorlock_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned DEBOUNCE_N = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [2:0] col_n,
    output logic [3:0] key_code,
    output logic [9:0] key_onehot,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned      DIV_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]       STABLE_MAX = 4'(DEBOUNCE_N);

    logic [3:0]          row_sync;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [1:0]          col_q, col_d;
    logic [NUM_KEYS-1:0] snap_q, snap_d;
    logic [NUM_KEYS-1:0] prev_q, prev_d;
    logic [3:0]          stable_cnt_q, stable_cnt_d;
    logic [3:0]          cand_q, cand_d;
    state_t              state_q, state_d;
    logic [3:0]          key_code_q, key_code_d;
    logic [9:0]          key_onehot_q, key_onehot_d;
    logic                key_valid_q, key_valid_d;
    logic                key_held_q, key_held_d;

    logic                frame_end;
    logic [3:0]          ones;
    logic [3:0]          single_idx;
    logic                is_single;
    logic                same;
    logic [3:0]          bit_idx;

    // Rows idle high, so the synchroniser resets to "nothing pressed".
    sync2 #(.WIDTH(4), .RST_VAL(4'b1111)) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (row_n),
        .q     (row_sync)
    );

    // Column scan: divider, column index, per-column row sampling and frame classification.
    always_comb begin
        div_d     = div_q + 1'b1;
        col_d     = col_q;
        snap_d    = snap_q;
        frame_end = 1'b0;
        bit_idx   = '0;
        if (div_q == DIV_LAST) begin
            div_d     = '0;
            col_d     = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
            frame_end = (col_q == 2'd2);
            for (int unsigned r = 0; r < NUM_ROWS; r++) begin
                bit_idx         = 4'(r * NUM_COLS) + {2'b00, col_q};
                snap_d[bit_idx] = ~row_sync[2'(r)];
            end
        end
        // The completed frame is snap_d, which already includes column 2.
        ones       = '0;
        single_idx = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (snap_d[4'(i)]) begin
                ones       = ones + 4'd1;
                single_idx = 4'(i);
            end
        end
        is_single = (ones == 4'd1);
        same      = (snap_d == prev_q);
    end

    // Debounce FSM and output registers, evaluated on frame end only.
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        stable_cnt_d = stable_cnt_q;
        cand_d       = cand_q;
        key_code_d   = key_code_q;
        key_onehot_d = key_onehot_q;
        key_valid_d  = 1'b0;
        key_held_d   = key_held_q;
        if (frame_end) begin
            prev_d       = snap_d;
            stable_cnt_d = !same ? 4'd1
                         : (stable_cnt_q < STABLE_MAX) ? stable_cnt_q + 4'd1 : STABLE_MAX;
            case (state_q)
                IDLE: begin
                    if (is_single) begin
                        state_d      = DEBOUNCE;
                        stable_cnt_d = 4'd1;
                        cand_d       = single_idx;
                    end
                end
                DEBOUNCE: begin
                    if (!same) begin
                        // A changed frame is re-evaluated as if arriving in IDLE.
                        if (is_single) begin
                            stable_cnt_d = 4'd1;
                            cand_d       = single_idx;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (stable_cnt_d >= STABLE_MAX) begin
                        state_d      = HELD;
                        key_code_d   = key_of_idx(cand_q);
                        key_onehot_d = (key_of_idx(cand_q) <= 4'd9)
                                     ? (10'd1 << key_of_idx(cand_q)) : '0;
                        key_valid_d  = 1'b1;
                        key_held_d   = 1'b1;
                    end
                end
                HELD: begin
                    if (snap_d != (NUM_KEYS'(1) << cand_q)) begin
                        state_d      = RELEASE;
                        stable_cnt_d = 4'd1;
                        key_held_d   = 1'b0;
                    end
                end
                RELEASE: begin
                    // stable_cnt_d counts consecutive identical frames; only
                    // all-clear frames may end the release.
                    if ((ones == 4'd0) && (stable_cnt_d >= STABLE_MAX)) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q        <= '0;
            col_q        <= '0;
            snap_q       <= '0;
            prev_q       <= '0;
            stable_cnt_q <= '0;
            cand_q       <= '0;
            state_q      <= IDLE;
            key_code_q   <= '0;
            key_onehot_q <= '0;
            key_valid_q  <= 1'b0;
            key_held_q   <= 1'b0;
        end else begin
            div_q        <= div_d;
            col_q        <= col_d;
            snap_q       <= snap_d;
            prev_q       <= prev_d;
            stable_cnt_q <= stable_cnt_d;
            cand_q       <= cand_d;
            state_q      <= state_d;
            key_code_q   <= key_code_d;
            key_onehot_q <= key_onehot_d;
            key_valid_q  <= key_valid_d;
            key_held_q   <= key_held_d;
        end
    end

    assign col_n      = ~(3'b001 << col_q);
    assign key_code   = key_code_q;
    assign key_onehot = key_onehot_q;
    assign key_valid  = key_valid_q;
    assign key_held   = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a keypad model and an expected-key scoreboard.
module tb_keypad_scanner;

    localparam int SD    = 4;
    localparam int DN    = 3;
    localparam int FRAME = 3 * SD;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] row_n;
    logic [2:0] col_n;
    logic [3:0] key_code;
    logic [9:0] key_onehot;
    logic       key_valid;
    logic       key_held;

    logic [11:0] pressed = '0;
    int          total = 0;
    int          bad = 0;
    int          pulses = 0;
    int          cyc = 0;
    int          last_pulse_cyc = 0;
    logic        prev_valid = 1'b0;
    int          exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_N(DN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .row_n      (row_n),
        .col_n      (col_n),
        .key_code   (key_code),
        .key_onehot (key_onehot),
        .key_valid  (key_valid),
        .key_held   (key_held)
    );

    // Keypad model: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row_n = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (pressed[r*3+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] onehot_of(input int code);
        return (code <= 9) ? (10'd1 << code) : 10'd0;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard: every key_valid pulse must match the oldest pending expected key.
    always @(negedge clk) begin
        int e;
        if (rst_n && key_valid) begin
            pulses++;
            last_pulse_cyc = cyc;
            chk("valid_one_cycle", 32'(prev_valid), 32'd0);
            chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_code", 32'(key_code), 32'(e));
                chk("sb_onehot", 32'(key_onehot), 32'(onehot_of(e)));
            end
        end
        prev_valid = key_valid;
    end

    initial begin
        int p0;
        int press_cyc;
        int lat;
        int n;
        logic [2:0] ec;

        // Reset hold
        rst_n = 1'b0;
        wait_cyc(3);
        chk("rst_col_n", 32'(col_n), 32'(3'b110));
        chk("rst_code", 32'(key_code), 32'd0);
        chk("rst_onehot", 32'(key_onehot), 32'd0);
        chk("rst_valid", 32'(key_valid), 32'd0);
        chk("rst_held", 32'(key_held), 32'd0);
        rst_n = 1'b1;

        // Column sequence after reset release: 4 cycles per column
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            ec = ~(3'b001 << ((k / 4) % 3));
            chk("col_scan", 32'(col_n), 32'(ec));
        end
        wait_cyc(2 * FRAME);

        // Key 5 held steady
        p0 = pulses;
        exp_q.push_back(5);
        press_cyc = cyc;
        pressed[4] = 1'b1;
        wait_cyc(5 * FRAME);
        chk("k5_pulses", 32'(pulses - p0), 32'd1);
        lat = last_pulse_cyc - press_cyc;
        chk("k5_latency", 32'((lat >= 2 * FRAME) && (lat <= (DN + 1) * FRAME + 3)), 32'd1);
        chk("k5_code", 32'(key_code), 32'd5);
        chk("k5_onehot", 32'(key_onehot), 32'(10'b0000100000));
        chk("k5_held", 32'(key_held), 32'd1);
        p0 = pulses;
        wait_cyc(10 * FRAME);
        chk("k5_no_repeat", 32'(pulses - p0), 32'd0);
        chk("k5_still_held", 32'(key_held), 32'd1);
        pressed = '0;
        wait_cyc(5 * FRAME);
        chk("k5_held_clear", 32'(key_held), 32'd0);
        chk("k5_code_kept", 32'(key_code), 32'd5);

        // Bouncing key 0, then steady
        p0 = pulses;
        for (int i = 0; i < 4; i++) begin
            pressed[10] = (i % 2 == 0);
            wait_cyc(7);
        end
        chk("k0_no_bounce_pulse", 32'(pulses - p0), 32'd0);
        exp_q.push_back(0);
        pressed[10] = 1'b1;
        wait_cyc(5 * FRAME);
        chk("k0_pulses", 32'(pulses - p0), 32'd1);
        chk("k0_code", 32'(key_code), 32'd0);
        chk("k0_onehot", 32'(key_onehot), 32'(10'b0000000001));
        pressed = '0;
        wait_cyc(5 * FRAME);

        // '#' twice with an idle gap
        p0 = pulses;
        exp_q.push_back(11);
        pressed[11] = 1'b1;
        wait_cyc(5 * FRAME);
        chk("hash1_pulses", 32'(pulses - p0), 32'd1);
        chk("hash1_code", 32'(key_code), 32'd11);
        chk("hash1_onehot", 32'(key_onehot), 32'd0);
        chk("hash1_held", 32'(key_held), 32'd1);
        pressed[11] = 1'b0;
        n = 0;
        while (key_held && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("hash_held_fall", 32'(key_held), 32'd0);
        chk("hash_fall_time", 32'(n <= FRAME + 2), 32'd1);
        wait_cyc(5 * FRAME);
        exp_q.push_back(11);
        pressed[11] = 1'b1;
        wait_cyc(5 * FRAME);
        chk("hash2_pulses", 32'(pulses - p0), 32'd2);
        chk("hash2_code", 32'(key_code), 32'd11);
        chk("hash2_onehot", 32'(key_onehot), 32'd0);
        pressed = '0;
        wait_cyc(5 * FRAME);

        // Keys 1 and 3 together: ghost/rollover frame never accepted
        p0 = pulses;
        pressed[0] = 1'b1;
        pressed[2] = 1'b1;
        wait_cyc(8 * FRAME);
        chk("multi_no_pulse", 32'(pulses - p0), 32'd0);
        chk("multi_not_held", 32'(key_held), 32'd0);
        pressed = '0;
        wait_cyc(5 * FRAME);

        // Key 1, add 9, drop 9: second key never reported while 1 stays down
        p0 = pulses;
        exp_q.push_back(1);
        pressed[0] = 1'b1;
        wait_cyc(5 * FRAME);
        chk("k1_pulses", 32'(pulses - p0), 32'd1);
        chk("k1_code", 32'(key_code), 32'd1);
        chk("k1_held", 32'(key_held), 32'd1);
        pressed[8] = 1'b1;
        wait_cyc(5 * FRAME);
        chk("k1k9_held_drop", 32'(key_held), 32'd0);
        pressed[8] = 1'b0;
        wait_cyc(5 * FRAME);
        chk("k1_no_second", 32'(pulses - p0), 32'd1);
        chk("k1_code_kept", 32'(key_code), 32'd1);
        pressed = '0;
        wait_cyc(5 * FRAME);
        chk("k1_after_release", 32'(pulses - p0), 32'd1);

        // Reset mid-debounce on key 7
        pressed[6] = 1'b1;
        wait_cyc(26);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_code", 32'(key_code), 32'd0);
        chk("mid_rst_onehot", 32'(key_onehot), 32'd0);
        chk("mid_rst_held", 32'(key_held), 32'd0);
        chk("mid_rst_valid", 32'(key_valid), 32'd0);
        chk("mid_rst_col_n", 32'(col_n), 32'(3'b110));
        wait_cyc(3);
        p0 = pulses;
        exp_q.push_back(7);
        rst_n = 1'b1;
        wait_cyc(5 * FRAME);
        chk("k7_pulses", 32'(pulses - p0), 32'd1);
        chk("k7_code", 32'(key_code), 32'd7);
        chk("k7_onehot", 32'(key_onehot), 32'(10'b0010000000));
        chk("k7_held", 32'(key_held), 32'd1);
        pressed = '0;
        wait_cyc(5 * FRAME);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
